reg_file_param: RTL and testbench

//  Parametrised system register file between the system controller and the UART/ALU datapath.

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_cmd_dec.sv | 28 ++
 rtl/reg_file_param.sv | 116 +++++++++++
 tb/tb_reg_file_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the system register file: default UART
// configuration values, names of the exported entries and the parity function.
package reg_file_pkg;

  localparam logic [7:0] CFG_RST      = 8'h41;
  localparam logic [7:0] PRESCALE_RST = 8'h20;

  typedef enum int unsigned {
    REG_ALU_A    = 0,
    REG_ALU_B    = 1,
    REG_UART_CFG = 2,
    REG_DIV      = 3
  } reg_idx_e;

  // Zero-extension leaves parity unchanged, so any entry up to 64 bits fits.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/reg_file_cmd_dec.sv
// Command decoder: classifies WrEn/RdEn/Address into a legal write, a legal
// read, an out-of-range read (which clears RdData) and a command error.
module reg_file_cmd_dec
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              WrEn,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] Address,
  output logic              wr_ok,
  output logic              rd_ok,
  output logic              rd_oor,
  output logic              err
);

  logic in_range;

  // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = ({1'b0, Address} < (ADDR_W + 1)'(DEPTH));

  assign wr_ok  = WrEn & ~RdEn & in_range;
  assign rd_ok  = RdEn & ~WrEn & in_range;
  assign rd_oor = RdEn & ~WrEn & ~in_range;
  assign err    = (WrEn & RdEn) | ((WrEn | RdEn) & ~in_range);

endmodule

// File: rtl/reg_file_param.sv
// Parametrised system register file with per-entry reset values, read-only
// entries and exported configuration. Optional parity: REG_FILE_PARITY_EN.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int                        DATA_W   = 8,
  parameter int                        DEPTH    = 16,
  parameter int                        ADDR_W   = 4,
  parameter int                        NUM_EXP  = 4,
  parameter logic [DEPTH*DATA_W-1:0]   RST_VALS = (DEPTH*DATA_W)'({PRESCALE_RST, CFG_RST, 16'h0000}),
  parameter logic [DEPTH-1:0]          RO_MASK  = '0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WrEn,
  input  logic                      RdEn,
  input  logic [ADDR_W-1:0]         Address,
  input  logic [DATA_W-1:0]         WrData,
  output logic [DATA_W-1:0]         RdData,
  output logic                      RdData_valid,
  output logic                      Cmd_err,
  output logic [NUM_EXP*DATA_W-1:0] REG_EXP
);

  logic              wr_ok, rd_ok, rd_oor, dec_err;
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rst_val [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg, cmd_err_reg, cmd_err_next;

  reg_file_cmd_dec #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_cmd_dec (
    .WrEn    (WrEn),
    .RdEn    (RdEn),
    .Address (Address),
    .wr_ok   (wr_ok),
    .rd_ok   (rd_ok),
    .rd_oor  (rd_oor),
    .err     (dec_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rst_val
      assign rst_val[gi] = RST_VALS[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < NUM_EXP; gi++) begin : g_exp
      assign REG_EXP[gi*DATA_W +: DATA_W] = mem_reg[gi];
    end
  endgenerate

  // Read-only entries are never assigned outside reset, so they fold to constants.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= rst_val[i];
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && !RO_MASK[i] && Address == ADDR_W'(i)) mem_reg[i] <= WrData;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (Address == ADDR_W'(i)) rd_word = mem_reg[i];
  end

`ifdef REG_FILE_PARITY_EN
  logic [DEPTH-1:0] par_reg;
  logic             rd_par;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) par_reg[i] <= even_parity(64'(rst_val[i]));
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && !RO_MASK[i] && Address == ADDR_W'(i))
          par_reg[i] <= even_parity(64'(WrData));
    end
  end

  always_comb begin
    rd_par = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (Address == ADDR_W'(i)) rd_par = par_reg[i];
  end

  // A corrupted entry is still returned, flagged by Cmd_err alongside the valid pulse.
  assign cmd_err_next = dec_err | (rd_ok & (even_parity(64'(rd_word)) != rd_par));
`else
  assign cmd_err_next = dec_err;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      cmd_err_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_ok;
      cmd_err_reg  <= cmd_err_next;
      if (rd_ok)
        rd_data_reg <= rd_word;
      else if (rd_oor)
        rd_data_reg <= '0;
    end
  end

  assign RdData       = rd_data_reg;
  assign RdData_valid = rd_valid_reg;
  assign Cmd_err      = cmd_err_reg;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param (DEPTH=12, entries 2/3 read-only):
// directed cases, randomized traffic and an asynchronous mid-run reset.
module tb_reg_file_param;

  localparam int               DW    = 8;
  localparam int               DEPTH = 12;
  localparam int               AW    = 4;
  localparam int               NE    = 4;
  localparam logic [DEPTH-1:0] RO    = 12'h00C;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          WrEn = 1'b0;
  logic          RdEn = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] WrData = '0;
  logic [DW-1:0] RdData;
  logic          RdData_valid;
  logic          Cmd_err;
  logic [NE*DW-1:0] REG_EXP;

  reg_file_param #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .ADDR_W  (AW),
    .NUM_EXP (NE),
    .RO_MASK (RO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_valid (RdData_valid),
    .Cmd_err      (Cmd_err),
    .REG_EXP      (REG_EXP)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [7:0]  rd;
    logic [31:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_txn = 0;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_rd;
  logic       extra_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a plain array of entries plus the last returned read value.
  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_mem[2] = 8'h41;
    m_mem[3] = 8'h20;
    m_rd = 8'h00;
  endfunction

  function automatic logic [31:0] model_exp();
    return {m_mem[3], m_mem[2], m_mem[1], m_mem[0]};
  endfunction

  task automatic issue(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    WrEn = wr; RdEn = rd; Address = a; WrData = d;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (wr && rd) begin
      e.err = 1'b1;
    end else if ((wr || rd) && int'(a) >= DEPTH) begin
      e.err = 1'b1;
      if (rd) m_rd = 8'h00;
    end else if (wr) begin
      if (!RO[a]) m_mem[a] = d;
    end else if (rd) begin
      m_rd = m_mem[a];
      e.valid = 1'b1;
    end
    e.err = e.err | extra_err;
    e.rd  = m_rd;
    e.exp = model_exp();
    @(posedge CLK);
    sb_q.push_back(e);
    n_txn++;
    $display("txn %0d: wr=%0d rd=%0d addr=%0d data=0x%02h -> exp valid=%0d err=%0d rd=0x%02h",
             n_txn, wr, rd, a, d, e.valid, e.err, e.rd);
    #1;
    WrEn = 1'b0; RdEn = 1'b0;
  endtask

  // Monitor: one expected response per clock after each issued command.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rd_valid", 32'(RdData_valid), 32'(e.valid));
      chk("cmd_err",  32'(Cmd_err),      32'(e.err));
      chk("rd_data",  32'(RdData),       32'(e.rd));
      chk("reg_exp",  REG_EXP,           e.exp);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0] r;
`ifdef REG_FILE_PARITY_EN
    logic flip_b;
`endif
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rd_data",  32'(RdData),       32'h0);
    chk("reset_rd_valid", 32'(RdData_valid), 32'h0);
    chk("reset_cmd_err",  32'(Cmd_err),      32'h0);
    chk("reset_reg_exp",  REG_EXP,           32'h2041_0000);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Write then read, including back-to-back reads and an idle cycle.
    issue(1'b1, 1'b0, 4'd5, 8'hA5);
    issue(1'b0, 1'b1, 4'd5, 8'h00);
    issue(1'b0, 1'b0, 4'd0, 8'h00);
    issue(1'b0, 1'b1, 4'd2, 8'h00);
    issue(1'b0, 1'b1, 4'd5, 8'h00);
    // Read-only entry write is dropped silently.
    issue(1'b1, 1'b0, 4'd2, 8'hFF);
    issue(1'b0, 1'b1, 4'd2, 8'h00);
    // Collision.
    issue(1'b1, 1'b0, 4'd1, 8'h11);
    issue(1'b1, 1'b1, 4'd1, 8'h3C);
    issue(1'b0, 1'b1, 4'd1, 8'h00);
    // Out-of-range read and write.
    issue(1'b0, 1'b1, 4'd13, 8'h00);
    issue(1'b1, 1'b0, 4'd12, 8'h77);
    issue(1'b0, 1'b1, 4'd11, 8'h00);
    // Read-after-write in the next cycle.
    issue(1'b1, 1'b0, 4'd0, 8'h5A);
    issue(1'b0, 1'b1, 4'd0, 8'h00);

    for (int k = 0; k < 1500; k++) begin
      r = 4'($urandom_range(0, 9));
      issue(r <= 4'd3 || r == 4'd8, (r >= 4'd4 && r <= 4'd8),
            4'($urandom_range(0, 15)), 8'($urandom));
    end

    // Asynchronous reset mid-run: outputs drop at once, contents reload.
    issue(1'b1, 1'b0, 4'd1, 8'hC3);
    issue(1'b0, 1'b1, 4'd1, 8'h00);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("async_rst_rd_data",  32'(RdData),       32'h0);
    chk("async_rst_rd_valid", 32'(RdData_valid), 32'h0);
    chk("async_rst_cmd_err",  32'(Cmd_err),      32'h0);
    chk("async_rst_reg_exp",  REG_EXP,           32'h2041_0000);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    issue(1'b0, 1'b1, 4'd1, 8'h00);
    issue(1'b0, 1'b1, 4'd3, 8'h00);

`ifdef REG_FILE_PARITY_EN
    issue(1'b1, 1'b0, 4'd4, 8'h0F);
    flip_b = dut.par_reg[4];
    force dut.par_reg[4] = ~flip_b;
    extra_err = 1'b1;
    issue(1'b0, 1'b1, 4'd4, 8'h00);
    extra_err = 1'b0;
    release dut.par_reg[4];
`endif

    issue(1'b0, 1'b0, 4'd0, 8'h00);
    issue(1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
